// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 64-bit carry-lookahead adder between two
// add/subtract requesters, with a registered valid/ready result channel.

module carry_lookahead_adder_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout,
  output logic        g,
  output logic        p
);

  // Carries out of positions 0..2 of a 4-wide lookahead cell; position 3 is
  // resolved one level up from the group generate/propagate.
  function automatic logic [2:0] cla_carries(input logic [3:0] gi, input logic [3:0] pi,
                                             input logic ci);
    logic [2:0] co;
    co[0] = gi[0] | (pi[0] & ci);
    co[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
    co[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
    return co;
  endfunction

  function automatic logic [1:0] group_gp(input logic [3:0] gi, input logic [3:0] pi);
    logic gg;
    logic pp;
    gg = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
    pp = &pi;
    return {gg, pp};
  endfunction

  logic [63:0] bit_g_s;
  logic [63:0] bit_p_s;
  logic [15:0] grp_g1_s;
  logic [15:0] grp_p1_s;
  logic [3:0]  grp_g2_s;
  logic [3:0]  grp_p2_s;
  logic [1:0]  top_gp_s;
  logic [3:0]  cin2_s;
  logic [15:0] cin1_s;
  logic [63:0] cin0_s;

  assign bit_g_s = a & b;
  assign bit_p_s = a ^ b;

  genvar j;
  generate
    for (j = 0; j < 16; j++) begin : g_l1
      assign {grp_g1_s[j], grp_p1_s[j]} = group_gp(bit_g_s[4*j +: 4], bit_p_s[4*j +: 4]);
      assign cin0_s[4*j +: 4] = {cla_carries(bit_g_s[4*j +: 4], bit_p_s[4*j +: 4], cin1_s[j]),
                                 cin1_s[j]};
    end
    for (j = 0; j < 4; j++) begin : g_l2
      assign {grp_g2_s[j], grp_p2_s[j]} = group_gp(grp_g1_s[4*j +: 4], grp_p1_s[4*j +: 4]);
      assign cin1_s[4*j +: 4] = {cla_carries(grp_g1_s[4*j +: 4], grp_p1_s[4*j +: 4], cin2_s[j]),
                                 cin2_s[j]};
    end
  endgenerate

  assign top_gp_s = group_gp(grp_g2_s, grp_p2_s);
  assign cin2_s   = {cla_carries(grp_g2_s, grp_p2_s, cin), cin};
  assign g        = top_gp_s[1];
  assign p        = top_gp_s[0];
  assign cout     = top_gp_s[1] | (top_gp_s[0] & cin);
  assign sum      = bit_p_s ^ cin0_s;

endmodule

module adder_arbiter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t           state_r;
  logic             last_grant_r;
  logic             res_id_r;
  logic [WIDTH-1:0] res_sum_r;
  logic             res_cout_r;
  logic             res_ovf_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  logic             grant_s;
  logic             can_accept_s;
  logic             accept_s;
  logic [WIDTH-1:0] op_a_s;
  logic [WIDTH-1:0] op_b_s;
  logic             op_sub_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             adder_g_unused_s;
  logic             adder_p_unused_s;

  // Round-robin grant: a lone requester wins, contention goes to the other side of last_grant.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // A full register that drains this cycle frees its slot for a new operation.
  assign can_accept_s = (state_r == ST_EMPTY) || res_ready;
  assign req0_ready   = (grant_s == 1'b0) && req0_valid && can_accept_s;
  assign req1_ready   = (grant_s == 1'b1) && req1_valid && can_accept_s;
  assign accept_s     = req0_ready || req1_ready;

  // Operand mux in front of the shared adder.
  always_comb begin
    op_a_s   = req0_a;
    op_b_s   = req0_b;
    op_sub_s = req0_sub;
    if (grant_s) begin
      op_a_s   = req1_a;
      op_b_s   = req1_b;
      op_sub_s = req1_sub;
    end else begin
      op_a_s   = req0_a;
      op_b_s   = req0_b;
      op_sub_s = req0_sub;
    end
  end

  assign b_eff_s = op_sub_s ? ~op_b_s : op_b_s;

  carry_lookahead_adder_64bit u_adder (
    .a    (op_a_s),
    .b    (b_eff_s),
    .cin  (op_sub_s),
    .sum  (sum_s),
    .cout (cout_s),
    .g    (adder_g_unused_s),
    .p    (adder_p_unused_s)
  );

  // Result register FSM and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_EMPTY;
      last_grant_r <= 1'b1;
      res_id_r     <= 1'b0;
      res_sum_r    <= {WIDTH{1'b0}};
      res_cout_r   <= 1'b0;
      res_ovf_r    <= 1'b0;
    end else if (accept_s) begin
      state_r      <= ST_FULL;
      last_grant_r <= grant_s;
      res_id_r     <= grant_s;
      res_sum_r    <= sum_s;
      res_cout_r   <= cout_s;
      res_ovf_r    <= signed_ovf(op_a_s[WIDTH-1], b_eff_s[WIDTH-1], sum_s[WIDTH-1]);
    end else begin
      case (state_r)
        ST_FULL:  state_r <= res_ready ? ST_EMPTY : ST_FULL;
        ST_EMPTY: state_r <= ST_EMPTY;
        default:  state_r <= ST_EMPTY;
      endcase
    end
  end

  // Completed-operation counters, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else begin
      if (req0_ready) begin
        cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt0_r <= cnt0_r;
      end
      if (req1_ready) begin
        cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt1_r <= cnt1_r;
      end
    end
  end

  assign res_valid = (state_r == ST_FULL);
  assign res_id    = res_id_r;
  assign res_sum   = res_sum_r;
  assign res_cout  = res_cout_r;
  assign res_ovf   = res_ovf_r;
  assign cnt0      = cnt0_r;
  assign cnt1      = cnt1_r;

endmodule
